// File: rtl/md_unit_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
package md_unit_pkg;

  localparam int unsigned XLEN = 32;

  // M-extension funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // funct7 that marks an R-type instruction as M-extension
  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_unit_if.sv
// Request/response bundle between the EX stage and the M-extension unit.
interface md_unit_if;
  import md_unit_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            stall;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  busy, done, result, stall
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output busy, done, result, stall
  );

endinterface

// File: rtl/md_operand_prep.sv
// Operand signedness, magnitudes and divide fast-path detection.
module md_operand_prep
  import md_unit_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            sign_a,
  output logic            sign_b,
  output logic [XLEN-1:0] abs_a,
  output logic [XLEN-1:0] abs_b,
  output logic            div_by_zero,
  output logic            div_overflow
);

  logic a_signed;
  logic b_signed;

  // Decode which operands are treated as two's complement, then take magnitudes
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    unique case (funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    sign_a       = a_signed & op_a[XLEN-1];
    sign_b       = b_signed & op_b[XLEN-1];
    abs_a        = sign_a ? (XLEN'(0) - op_a) : op_a;
    abs_b        = sign_b ? (XLEN'(0) - op_b) : op_b;
    div_by_zero  = funct3[2] & (op_b == '0);
    div_overflow = funct3[2] & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}})
                   & (op_b == '1);
  end

endmodule

// File: rtl/md_unit.sv
// Iterative shift-add multiplier / restoring divider for RV32M, one bit per cycle.
module md_unit
  import md_unit_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  md_unit_if.slave bus
);

  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned CNT_W = $clog2(XLEN);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;     // mul: {product hi, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]  opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2:0]       f3_q, f3_d;
  logic             neg_q, neg_d;     // product / quotient negation
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic             sign_a, sign_b, div_by_zero, div_overflow;
  logic [XLEN-1:0]  abs_a, abs_b;

  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    div_shift;
  logic [XLEN-1:0]  div_diff;
  logic             div_ge;
  logic [PW-1:0]    step;
  logic [PW-1:0]    prod_fix;
  logic [XLEN-1:0]  quo_fix, rem_fix, final_res;

  md_operand_prep u_prep (
    .funct3       (bus.funct3),
    .op_a         (bus.op_a),
    .op_b         (bus.op_b),
    .sign_a       (sign_a),
    .sign_b       (sign_b),
    .abs_a        (abs_a),
    .abs_b        (abs_b),
    .div_by_zero  (div_by_zero),
    .div_overflow (div_overflow)
  );

  // One multiply or divide iteration applied to the accumulator
  always_comb begin
    mul_sum   = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = acc_q[PW-1:XLEN-1];
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    div_ge    = div_shift >= {1'b0, opnd_q};
    if (f3_q[2]) begin
      step = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end else begin
      step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign correction and result selection from the final iteration
  always_comb begin
    prod_fix = neg_q ? (PW'(0) - step) : step;
    quo_fix  = neg_q ? (XLEN'(0) - step[XLEN-1:0]) : step[XLEN-1:0];
    rem_fix  = neg_rem_q ? (XLEN'(0) - step[PW-1:XLEN]) : step[PW-1:XLEN];
    if (f3_q == F3_MUL) begin
      final_res = prod_fix[XLEN-1:0];
    end else if (!f3_q[2]) begin
      final_res = prod_fix[PW-1:XLEN];
    end else if (f3_q[1]) begin
      final_res = rem_fix;
    end else begin
      final_res = quo_fix;
    end
  end

  // Next-state, counter and datapath updates; flush overrides everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    f3_d      = f3_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    result_d  = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          f3_d      = bus.funct3;
          neg_d     = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          cnt_d     = '0;
          if (div_by_zero) begin
            result_d = bus.funct3[1] ? bus.op_a : '1;
            state_d  = ST_DONE;
            done_d   = 1'b1;
          end else if (div_overflow) begin
            result_d = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d  = ST_DONE;
            done_d   = 1'b1;
          end else begin
            acc_d   = {XLEN'(0), (bus.funct3[2] ? abs_a : abs_b)};
            opnd_d  = bus.funct3[2] ? abs_b : abs_a;
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        acc_d  = step;
        cnt_d  = cnt_q + CNT_W'(1);
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          cnt_d    = '0;
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = final_res;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (bus.flush) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      f3_q      <= f3_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.stall  = ~rst & (((state_q == ST_IDLE) & bus.start & ~bus.flush)
                              | (state_q == ST_RUN));

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, random ops against a
// reference model, and flush / reset / held-start sequences.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk;
  logic rst;
  md_unit_if bus();

  md_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_res;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // RV32M semantics computed with wide arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ea  = (f3 != 3'd3) ? {{32{a[31]}}, a} : {32'd0, a};
    eb  = (f3 == 3'd0 || f3 == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p   = ea * eb;
    case (f3)
      3'd0:    return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, hold start while stalled, check result, latency and pulse shape
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit fast,
                        input bit hold);
    int cyc, busy_n, stall_n;
    bit got;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    #1;
    stall_n = bus.stall ? 1 : 0;
    busy_n  = 0;
    cyc     = 0;
    got     = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.done) got = 1'b1;
      else begin
        if (bus.busy)  busy_n++;
        if (bus.stall) stall_n++;
      end
    end
    chk({name, " done_seen"}, 64'(got), 64'd1);
    chk({name, " result"}, 64'(bus.result), 64'(exp));
    chk({name, " latency"}, 64'(cyc), fast ? 64'd1 : 64'd33);
    chk({name, " busy_cycles"}, 64'(busy_n), fast ? 64'd0 : 64'd32);
    chk({name, " stall_cycles"}, 64'(stall_n), fast ? 64'd1 : 64'd33);
    chk({name, " stall_in_done"}, 64'(bus.stall), 64'd0);
    if (!hold) bus.start = 1'b0;
    @(negedge clk);
    chk({name, " done_pulse_end"}, 64'(bus.done), 64'd0);
    chk({name, " busy_after"}, 64'(bus.busy), 64'd0);
    chk({name, " result_hold"}, 64'(bus.result), 64'(exp));
    if (hold) begin
      bus.start = 1'b0;
      @(negedge clk);
      chk({name, " no_retrigger_done"}, 64'(bus.done), 64'd0);
      chk({name, " no_retrigger_busy"}, 64'(bus.busy), 64'd0);
    end
    last_res = exp;
  endtask

  initial begin
    vt[0]  = '{"MUL_7_m3",      F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vt[1]  = '{"MULH_min_min",  F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
    vt[2]  = '{"MULHU_ones",    F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vt[3]  = '{"MULHSU_ones",   F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vt[4]  = '{"DIV_m7_2",      F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    vt[5]  = '{"REM_m7_2",      F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vt[6]  = '{"DIVU_100_7",    F3_DIVU,   32'd100,        32'd7,         32'd14,        1'b0};
    vt[7]  = '{"REMU_100_7",    F3_REMU,   32'd100,        32'd7,         32'd2,         1'b0};
    vt[8]  = '{"DIV_5_0",       F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
    vt[9]  = '{"REMU_5_0",      F3_REMU,   32'd5,          32'd0,         32'd5,         1'b1};
    vt[10] = '{"DIV_ovf",       F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vt[11] = '{"REM_ovf",       F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1};

    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.flush  = 1'b0;
    bus.funct3 = F3_MUL;
    bus.op_a   = 32'd3;
    bus.op_b   = 32'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset result", 64'(bus.result), 64'd0);
    chk("reset stall_forced_low", 64'(bus.stall), 64'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("idle stall_no_start", 64'(bus.stall), 64'd0);

    for (int i = 0; i < 12; i++)
      run_op(vt[i].name, vt[i].f3, vt[i].a, vt[i].b, vt[i].exp, vt[i].fast, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      bit fast;
      int sel;
      f3  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (sel == 2) b = 32'($urandom_range(1, 20));
      fast = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      run_op($sformatf("rand%0d_f3_%0d", i, f3), f3, a, b, ref_md(f3, a, b), fast, 1'b0);
    end

    // Flush at RUN iteration 10, with start still high
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = F3_MULHU;
    bus.op_a   = 32'hFFFF_FFFF;
    bus.op_b   = 32'hFFFF_FFFF;
    repeat (11) @(negedge clk);
    chk("flush pre_busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush busy_drop", 64'(bus.busy), 64'd0);
    chk("flush no_done", 64'(bus.done), 64'd0);
    chk("flush result_kept", 64'(bus.result), 64'(last_res));
    chk("flush beats_start_stall", 64'(bus.stall), 64'd0);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("flush idle_no_done", 64'(bus.done), 64'd0);
    chk("flush idle_no_busy", 64'(bus.busy), 64'd0);
    chk("flush idle_result", 64'(bus.result), 64'(last_res));
    run_op("post_flush_MULHU_3_5", F3_MULHU, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0);

    // Reset in the middle of RUN
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = F3_MUL;
    bus.op_a   = 32'd7;
    bus.op_b   = 32'd9;
    repeat (5) @(negedge clk);
    run_mid_rst_check();

    // start held high through DONE must give a single done pulse
    run_op("held_start_DIVU", F3_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0, 1'b1);
    run_op("held_start_DIV0", F3_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  task automatic run_mid_rst_check();
    chk("midrun busy_before_rst", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrun stall_forced_low", 64'(bus.stall), 64'd0);
    @(negedge clk);
    chk("midrun rst busy", 64'(bus.busy), 64'd0);
    chk("midrun rst done", 64'(bus.done), 64'd0);
    chk("midrun rst result", 64'(bus.result), 64'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("after_rst idle_busy", 64'(bus.busy), 64'd0);
    run_op("after_rst_MUL_7_9", F3_MUL, 32'd7, 32'd9, 32'd63, 1'b0, 1'b0);
  endtask

endmodule
